// File: rtl/debug_key_ctrl.sv
// Debug key / LED / UART pad controller for the cart transceiver banks.
// Long-press detection is built only when DEBUG_KEY_CTRL_LONG_PRESS_EN is defined.
module debug_key_ctrl #(
   parameter int unsigned NUM_KEYS     = 1,
   parameter int unsigned DEBOUNCE_CYC = 74250,
   parameter int unsigned LONG_CYC     = 74250000,
   parameter int unsigned BLINK_CYC    = 18562500
) (
   input  logic                clk,
   input  logic                reset,
   output logic                cart_tran_bank0_dir,
   output logic [7:4]          cart_tran_bank0,
   output logic                cart_tran_bank3_dir,
   input  logic [7:0]          cart_tran_bank3,
   output logic                cart_tran_pin31_dir,
   input  logic                cart_tran_pin31,
   input  logic [1:0]          led_mode,
   input  logic                uart_tx,
   output logic                uart_rx,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long
);

   localparam int unsigned DW     = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned PERIOD = 2 * BLINK_CYC;
   localparam int unsigned BW     = $clog2(PERIOD);
   localparam int unsigned FAST_Q = BLINK_CYC / 4;

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(PERIOD - 1);
   localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_CYC);
   localparam logic [BW-1:0] FAST_DIV   = BW'(FAST_Q);

   // Pad directions and fixed drive levels
   assign cart_tran_bank0_dir = 1'b1;
   assign cart_tran_bank3_dir = 1'b0;
   assign cart_tran_pin31_dir = 1'b0;

   logic led;
   assign cart_tran_bank0 = {1'b0, uart_tx, led, 1'b0};

   // Key pads above NUM_KEYS are deliberately ignored
   logic unused_pads;
   assign unused_pads = ^cart_tran_bank3;

   // UART RX synchroniser, idles high
   logic [1:0] rx_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_sync <= 2'b11;
      end else begin
         rx_sync <= {rx_sync[0], cart_tran_pin31};
      end
   end

   assign uart_rx = rx_sync[1];

   // Key synchronisers carry the raw pad so the all-ones reset state reads as released
   logic [NUM_KEYS-1:0] pad_s1;
   logic [NUM_KEYS-1:0] pad_s2;
   logic [NUM_KEYS-1:0] sample;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pad_s1 <= '1;
         pad_s2 <= '1;
      end else begin
         pad_s1 <= cart_tran_bank3[NUM_KEYS-1:0];
         pad_s2 <= pad_s1;
      end
   end

   assign sample = ~pad_s2;

   // Per-key debounce: a change is accepted after DEBOUNCE_CYC consecutive differing samples
   logic [DW-1:0] deb_cnt [NUM_KEYS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            deb_cnt[k] <= '0;
         end
         key_level <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (sample[k] == key_level[k]) begin
               deb_cnt[k] <= '0;
            end else if (deb_cnt[k] == DEB_LAST) begin
               deb_cnt[k]   <= '0;
               key_level[k] <= sample[k];
            end else begin
               deb_cnt[k] <= deb_cnt[k] + DW'(1);
            end
         end
      end
   end

   // Edge pulses, one cycle after the debounced level moves
   logic [NUM_KEYS-1:0] level_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q     <= '0;
         key_press   <= '0;
         key_release <= '0;
      end else begin
         level_q     <= key_level;
         key_press   <= key_level & ~level_q;
         key_release <= ~key_level & level_q;
      end
   end

`ifdef DEBUG_KEY_CTRL_LONG_PRESS_EN
   localparam int unsigned   HW       = $clog2(LONG_CYC + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);

   logic [HW-1:0]       hold_cnt [NUM_KEYS];
   logic [NUM_KEYS-1:0] long_hit;
   logic [NUM_KEYS-1:0] long_hit_q;

   always_comb begin
      long_hit = '0;
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
         long_hit[k] = (hold_cnt[k] == HOLD_MAX);
      end
   end

   // Hold counters saturate, so the rising edge of long_hit fires once per press
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            hold_cnt[k] <= '0;
         end
         long_hit_q <= '0;
         key_long   <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (!key_level[k]) begin
               hold_cnt[k] <= '0;
            end else if (!long_hit[k]) begin
               hold_cnt[k] <= hold_cnt[k] + HW'(1);
            end
         end
         long_hit_q <= long_hit;
         key_long   <= long_hit & ~long_hit_q;
      end
   end
`else
   logic unused_long_cfg;
   assign unused_long_cfg = ^LONG_CYC;
   assign key_long        = '0;
`endif

   // Free-running blink timebase, never disturbed by led_mode
   logic [BW-1:0] blink_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   logic [BW-1:0] fast_idx;
   logic          slow_phase;
   logic          fast_phase;
   logic          led_next;

   assign fast_idx   = blink_cnt / FAST_DIV;
   assign slow_phase = (blink_cnt < BLINK_HALF);
   assign fast_phase = ~fast_idx[0];

   always_comb begin
      led_next = 1'b0;
      case (led_mode)
         2'd1:    led_next = 1'b1;
         2'd2:    led_next = slow_phase;
         2'd3:    led_next = fast_phase;
         default: led_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led <= 1'b0;
      end else begin
         led <= led_next;
      end
   end

endmodule

// File: tb/tb_debug_key_ctrl.sv
// Scoreboard bench for debug_key_ctrl: a segment-level key model predicts event cycles,
// a monitor pops and compares them, and LED/UART/pad outputs are checked every cycle.
module tb_debug_key_ctrl;

   localparam int NK    = 2;
   localparam int DEB   = 8;
   localparam int LONG  = 32;
   localparam int BLINK = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          bank0_dir;
   logic [7:4]    bank0;
   logic          bank3_dir;
   logic [7:0]    bank3;
   logic          pin31_dir;
   logic          pin31;
   logic [1:0]    led_mode;
   logic          uart_tx;
   logic          uart_rx;
   logic [NK-1:0] key_level;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic [NK-1:0] key_long;

   always #5 clk = ~clk;

   debug_key_ctrl #(
      .NUM_KEYS(NK), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .BLINK_CYC(BLINK)
   ) dut (
      .clk(clk), .reset(rst),
      .cart_tran_bank0_dir(bank0_dir), .cart_tran_bank0(bank0),
      .cart_tran_bank3_dir(bank3_dir), .cart_tran_bank3(bank3),
      .cart_tran_pin31_dir(pin31_dir), .cart_tran_pin31(pin31),
      .led_mode(led_mode), .uart_tx(uart_tx), .uart_rx(uart_rx),
      .key_level(key_level), .key_press(key_press),
      .key_release(key_release), .key_long(key_long)
   );

   int cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   int checks = 0;
   int passes = 0;

   // Expected pulse cycles: kind 0 press, 1 release, 2 long
   int exp_q [3][NK][$];
   int seg_val [NK][$];
   int seg_len [NK][$];
   bit plan [NK][$];
   bit pin_prev;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic string kname(input int kind);
      if (kind == 0) return "key_press";
      if (kind == 1) return "key_release";
      return "key_long";
   endfunction

   task automatic add_seg(input int k, input int p, input int len);
      int last;
      if (seg_val[k].size() > 0 && seg_val[k][seg_val[k].size()-1] == p) begin
         last = seg_len[k].size() - 1;
         seg_len[k][last] = seg_len[k][last] + len;
      end else begin
         seg_val[k].push_back(p);
         seg_len[k].push_back(len);
      end
      repeat (len) plan[k].push_back(p[0]);
   endtask

   task automatic clear_plan();
      for (int k = 0; k < NK; k++) begin
         plan[k].delete();
         seg_val[k].delete();
         seg_len[k].delete();
      end
   endtask

   task automatic finish_plan();
      int mx;
      mx = 0;
      for (int k = 0; k < NK; k++) begin
         add_seg(k, 0, DEB + 12);
         if (plan[k].size() > mx) mx = plan[k].size();
      end
      for (int k = 0; k < NK; k++)
         if (plan[k].size() < mx) add_seg(k, 0, mx - plan[k].size());
   endtask

   // A pad segment of value p lasting L cycles, first captured on edge t, flips the
   // debounced level on edge t+DEB+1 if it differs from the level and L >= DEB.
   task automatic model_key(input int k);
      int level, t, rise, p, len, tog;
      level = 0; t = 1; rise = 0;
      for (int i = 0; i < seg_val[k].size(); i++) begin
         p = seg_val[k][i];
         len = seg_len[k][i];
         if (p != level && len >= DEB) begin
            tog = t + DEB + 1;
            exp_q[p != 0 ? 0 : 1][k].push_back(tog + 1);
`ifdef DEBUG_KEY_CTRL_LONG_PRESS_EN
            if (p == 0 && tog - rise >= LONG) exp_q[2][k].push_back(rise + LONG + 1);
`endif
            if (p != 0) rise = tog;
            level = p;
         end
         t = t + len;
      end
   endtask

   task automatic drive_plan();
      int n_cyc;
      n_cyc = plan[0].size();
      for (int n = 0; n < n_cyc; n++) begin
         for (int k = 0; k < NK; k++) bank3[k] = ~plan[k][n];
         bank3[7:2] = 6'($urandom);
         pin31      = 1'($urandom);
         uart_tx    = 1'($urandom);
         if (n % 40 == 0) led_mode = 2'((n / 40) % 4);
         @(negedge clk);
      end
   endtask

   task automatic check_kind(input int kind, input logic [NK-1:0] v);
      int t;
      for (int k = 0; k < NK; k++) begin
         if (v[k]) begin
            if (exp_q[kind][k].size() == 0) begin
               checks++;
               $display("FAIL %s[%0d]: pulse at cycle %0d, required none", kname(kind), k, cyc);
            end else begin
               t = exp_q[kind][k].pop_front();
               chk($sformatf("%s[%0d] cycle", kname(kind), k), cyc, t);
            end
            if (kind == 0) chk($sformatf("key_level[%0d] at press", k), key_level[k], 1);
            if (kind == 1) chk($sformatf("key_level[%0d] at release", k), key_level[k], 0);
         end
         while (exp_q[kind][k].size() > 0 && exp_q[kind][k][0] < cyc) begin
            checks++;
            $display("FAIL %s[%0d]: no pulse, required at cycle %0d (now %0d)",
                     kname(kind), k, exp_q[kind][k][0], cyc);
            void'(exp_q[kind][k].pop_front());
         end
      end
   endtask

   task automatic check_leftovers();
      for (int kind = 0; kind < 3; kind++)
         for (int k = 0; k < NK; k++)
            chk($sformatf("%s[%0d] pending", kname(kind), k), exp_q[kind][k].size(), 0);
   endtask

   task automatic check_reset_outputs();
      chk("reset outputs zero", longint'({key_level, key_press, key_release, key_long, bank0[5]}), 0);
      chk("reset uart_rx", uart_rx, 1);
   endtask

   // Monitor: event scoreboard plus per-cycle LED, UART RX and pad checks
   always @(posedge clk) begin
      int m, exp_led;
      #1;
      if (!rst && cyc > 0) begin
         check_kind(0, key_press);
         check_kind(1, key_release);
         check_kind(2, key_long);
         m = (cyc - 1) % (2 * BLINK);
         case (led_mode)
            2'd0:    exp_led = 0;
            2'd1:    exp_led = 1;
            2'd2:    exp_led = (m < BLINK) ? 1 : 0;
            default: exp_led = ((m / (BLINK / 4)) % 2 == 0) ? 1 : 0;
         endcase
         chk("led bank0[5]", bank0[5], exp_led);
         chk("uart_rx", uart_rx, (cyc >= 2) ? pin_prev : 1);
         chk("static pads", {bank0_dir, bank3_dir, pin31_dir, bank0[7], bank0[6], bank0[4]},
             {3'b100, 1'b0, uart_tx, 1'b0});
      end
      pin_prev = pin31;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: run did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int p, len, sel;
      rst = 1'b1; bank3 = '1; pin31 = 1'b1; led_mode = 2'd0; uart_tx = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs();

      // Simultaneous long presses, a glitch train, exact-threshold segments, then random
      add_seg(0, 1, 100); add_seg(1, 1, 100);
      add_seg(0, 0, 20);  add_seg(1, 0, 20);
      repeat (4) begin add_seg(0, 1, 5); add_seg(0, 0, 5); end
      add_seg(1, 1, DEB); add_seg(1, 0, DEB - 1); add_seg(1, 1, DEB - 1); add_seg(1, 0, 30);
      for (int k = 0; k < NK; k++) begin
         p = 1;
         repeat (10) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      len = int'($urandom_range(1, DEB - 1));
            else if (sel == 1) len = int'($urandom_range(DEB, DEB + 20));
            else               len = int'($urandom_range(LONG, LONG + 30));
            add_seg(k, p, len);
            p = 1 - p;
         end
      end
      finish_plan();
      for (int k = 0; k < NK; k++) model_key(k);
      rst = 1'b0;
      drive_plan();
      repeat (5) @(negedge clk);
      check_leftovers();

      // Reset arrives part-way through a debounce; TX must keep passing through
      bank3[0] = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs();
      for (int i = 0; i < 4; i++) begin
         uart_tx = ~uart_tx;
         #1;
         chk("bank0[6] follows uart_tx in reset", bank0[6], uart_tx);
         @(negedge clk);
      end
      check_reset_outputs();

      // Key still held as reset releases
      clear_plan();
      add_seg(0, 1, 70);
      add_seg(1, 0, 70);
      finish_plan();
      for (int k = 0; k < NK; k++) model_key(k);
      rst = 1'b0;
      drive_plan();
      repeat (5) @(negedge clk);
      check_leftovers();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/debug_key_ctrl.md
DEBUG_KEY_CTRL -- requirements
Module: debug_key_ctrl

Interface
REQ-001 Parameter NUM_KEYS, default 1: active-low key inputs sampled on cart_tran_bank3[NUM_KEYS-1:0]; legal range 1..8.
REQ-002 Parameter DEBOUNCE_CYC, default 74250: stable-sample count required to accept a key change; legal range >=2.
REQ-003 Parameter LONG_CYC, default 74250000: held-pressed count that raises a long-press event; legal range > DEBOUNCE_CYC.
REQ-004 Parameter BLINK_CYC, default 18562500: LED half-period in blink mode; fast blink is BLINK_CYC/4; legal range >=4.
REQ-005 clk  input  1  sole clock; every flop is clocked by it.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 cart_tran_bank0_dir  output  1  bank 0 direction; 1 drives the bank.
REQ-008 cart_tran_bank0  output  [7:4]  bank 0 pad drive; bit 5 carries the LED, bit 6 carries UART TX.
REQ-009 cart_tran_bank3_dir  output  1  bank 3 direction; 0 receives.
REQ-010 cart_tran_bank3  input  [7:0]  raw key pads, active-low.
REQ-011 cart_tran_pin31_dir  output  1  pin 31 direction; 0 receives.
REQ-012 cart_tran_pin31  input  1  raw UART RX pad.
REQ-013 led_mode  input  [1:0]  LED mode: 0 off, 1 on, 2 slow blink, 3 fast blink.
REQ-014 uart_tx  input  1  UART TX from the core, passed to the pad.
REQ-015 uart_rx  output  1  synchronised UART RX to the core.
REQ-016 key_level  output  [NUM_KEYS-1:0]  debounced state; 1 means pressed.
REQ-017 key_press  output  [NUM_KEYS-1:0]  one-cycle pulse on a debounced press.
REQ-018 key_release  output  [NUM_KEYS-1:0]  one-cycle pulse on a debounced release.
REQ-019 key_long  output  [NUM_KEYS-1:0]  one-cycle pulse on a long press.

Function
REQ-020 cart_tran_bank0_dir SHALL be constant 1; cart_tran_bank3_dir and cart_tran_pin31_dir SHALL be constant 0.
REQ-021 cart_tran_bank0[4] and cart_tran_bank0[7] SHALL be constant 0.
REQ-022 cart_tran_bank0[6] SHALL equal uart_tx combinationally, with no register in the path.
REQ-023 uart_rx SHALL be cart_tran_pin31 through a 2-flop synchroniser (latency 2 cycles) and SHALL reset to 1.
REQ-024 Each key pad SHALL be inverted and then passed through its own 2-flop synchroniser.
REQ-025 Per key, a counter SHALL clear whenever the synchronised sample equals key_level and increment otherwise.
REQ-026 key_level SHALL toggle when that counter reaches DEBOUNCE_CYC-1 while the sample still differs; the counter clears on the same cycle.
REQ-027 key_press or key_release SHALL pulse high on the cycle after key_level rises or falls, for exactly 1 cycle.
REQ-028 Per key, a hold counter SHALL count while key_level=1, saturate at LONG_CYC, and clear when key_level=0.
REQ-029 key_long SHALL pulse exactly once per press, on the cycle the hold counter reaches LONG_CYC.
REQ-030 Keys SHALL be fully independent; simultaneous events on several keys SHALL each pulse on their own bits in the same cycle.
REQ-031 A free-running blink counter SHALL wrap at 2*BLINK_CYC-1.
REQ-032 LED phase SHALL be high in the first half of the blink period for slow blink, and SHALL use counter bits scaled by 1/4 for fast blink.
REQ-033 cart_tran_bank0[5] SHALL be registered and driven from led_mode and LED phase, 1-cycle latency.
REQ-034 A led_mode change SHALL NOT reset the blink counter.
REQ-035 Counter widths SHALL be $clog2(parameter+1); no counter SHALL wrap, except the blink counter.

Reset
REQ-036 While reset=1, every counter, key_level, key_press, key_release, key_long and LED flop SHALL be 0, and both synchronisers SHALL hold 1.
REQ-037 When reset asserts mid-press, no event SHALL be emitted.
REQ-038 After reset deasserts, a key held down SHALL produce key_press after the synchroniser delay plus DEBOUNCE_CYC cycles.

Configuration
REQ-039 With macro DEBUG_KEY_CTRL_LONG_PRESS_EN defined, the hold counters and key_long SHALL be implemented as in REQ-028 and REQ-029.
REQ-040 With DEBUG_KEY_CTRL_LONG_PRESS_EN undefined, key_long SHALL be constant 0 and no hold-counter logic SHALL be synthesised.

Verification
REQ-041 Set NUM_KEYS=2, DEBOUNCE_CYC=8, and drive bank3[0] low steadily -> key_level[0]=1 and key_press[0] pulses once, 11 cycles after the edge; key 1 stays idle.
REQ-042 Drive bank3[0] with 5-cycle glitches against DEBOUNCE_CYC=8 -> no key_level change and no pulses.
REQ-043 Set LONG_CYC=32 and hold key 0 for 100 cycles -> exactly one key_long[0] pulse, 32 cycles after key_press[0]; key_release[0] follows the release.
REQ-044 Set BLINK_CYC=8 and led_mode=2 -> bank0[5] toggles every 8 cycles; led_mode=3 -> toggles every 2 cycles; led_mode=0 or 1 -> constant 0 or 1.
REQ-045 Assert reset mid-debounce with uart_tx toggling -> all outputs are 0 except uart_rx=1, and bank0[6] keeps following uart_tx.
REQ-046 Build without DEBUG_KEY_CTRL_LONG_PRESS_EN and rerun REQ-043 -> key_long stays 0; press and release behave identically.
